// File: rtl/edge_frame_writer.sv
// edge_frame_writer
//
// Purpose:
//   Turns a stream of interior gradient magnitudes ((IMG_W-2) x (IMG_H-2)
//   values in raster order) into a complete IMG_W x IMG_H 8-bit edge frame.
//   Border pixels are produced as 0x00 without consuming input. Interior
//   pixels are either saturated to 8 bits (THRESH = 0) or binarized against
//   THRESH.
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   in_valid    in_mag carries a valid magnitude
//   in_mag      11-bit unsigned |Gx|+|Gy| magnitude
//   in_ready    block accepts in_mag this cycle
//   out_valid   out_pixel / out_sof / out_eol are valid
//   out_ready   downstream accepts the output this cycle
//   out_pixel   8-bit output pixel
//   out_sof     output is frame position (0,0)
//   out_eol     output is the last column of its line
//   frame_done  one-cycle pulse while the final pixel transfers downstream

`timescale 1ns/1ps

module edge_frame_writer #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int THRESH = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [10:0] in_mag,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_pixel,
    output logic        out_sof,
    output logic        out_eol,
    output logic        frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [10:0]   THR      = 11'(THRESH);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t          state_q;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            allLoaded_q;
    logic            outLast_q;
    logic            out_valid_q;
    logic [7:0]      out_pixel_q, out_pixel_d;
    logic            out_sof_q;
    logic            out_eol_q;

    logic            isInterior;
    logic            isLastPos;
    logic            canLoad;
    logic            load;
    logic            outXfer;

    // Position decode for the next pixel to be loaded into the output
    // register, plus the load/handshake decisions. allLoaded_q keeps the
    // wrapped counters from starting a second frame while the last pixel
    // is still waiting for downstream.
    always_comb begin
        isInterior = (row_q != '0) && (row_q != ROW_LAST) &&
                     (col_q != '0) && (col_q != COL_LAST);
        isLastPos  = (row_q == ROW_LAST) && (col_q == COL_LAST);
        canLoad    = (state_q == ACTIVE) && !allLoaded_q &&
                     (!out_valid_q || out_ready);
        load       = canLoad && (!isInterior || in_valid);
        in_ready   = canLoad && isInterior;
        outXfer    = out_valid_q && out_ready;
        frame_done = outXfer && outLast_q;
    end

    // Pixel value for the position being loaded. The threshold compare uses
    // the full 11-bit magnitude, not the saturated value.
    always_comb begin
        out_pixel_d = 8'h00;
        if (isInterior) begin
            if (THRESH == 0) begin
                out_pixel_d = (in_mag > 11'd255) ? 8'hFF : in_mag[7:0];
            end else begin
                out_pixel_d = (in_mag >= THR) ? 8'hFF : 8'h00;
            end
        end
    end

    // Raster counters: column wraps into a row increment, row wraps to 0
    // after the last line.
    always_comb begin
        col_d = col_q + 1'b1;
        row_d = row_q;
        if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end
    end

    // Main FSM. IDLE waits for in_valid without consuming it; ACTIVE walks
    // the frame, loading one position per cycle whenever the output
    // register is free or draining, and returns to IDLE as the final
    // pixel is accepted downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            allLoaded_q <= 1'b0;
            outLast_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_pixel_q <= 8'h00;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (load) begin
                        out_valid_q <= 1'b1;
                        out_pixel_q <= out_pixel_d;
                        out_sof_q   <= (row_q == '0) && (col_q == '0);
                        out_eol_q   <= (col_q == COL_LAST);
                        outLast_q   <= isLastPos;
                        row_q       <= row_d;
                        col_q       <= col_d;
                        if (isLastPos) begin
                            allLoaded_q <= 1'b1;
                        end
                    end else if (outXfer) begin
                        out_valid_q <= 1'b0;
                    end
                    if (frame_done) begin
                        state_q     <= IDLE;
                        allLoaded_q <= 1'b0;
                        outLast_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_edge_frame_writer.sv
// tb_edge_frame_writer
//
// Purpose:
//   Directed bench for edge_frame_writer on a 4x4 frame. Two instances run
//   in lockstep on the same handshake signals: dutA with THRESH=0 and dutB
//   with THRESH=100, each fed its own magnitude pattern.
//
// Ports: none (top-level bench).

`timescale 1ns/1ps

module tb_edge_frame_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        outReady;
    logic [10:0] magA, magB;
    logic        inReadyA, outValidA, sofA, eolA, doneA;
    logic        inReadyB, outValidB, sofB, eolB, doneB;
    logic [7:0]  pixA, pixB;

    int checkCnt = 0;
    int passCnt  = 0;

    int dataA[4] = '{10, 300, 255, 0};
    int dataB[4] = '{99, 100, 2047, 0};
    int expA[16] = '{0, 0, 0, 0,  0, 10, 255, 0,  0, 255, 0, 0,  0, 0, 0, 0};
    int expB[16] = '{0, 0, 0, 0,  0, 0, 255, 0,   0, 255, 0, 0,  0, 0, 0, 0};

    int capPixA[64];
    int capPixB[64];
    int capCyc[64];
    logic [2:0] capFlags[64];
    int nX, doneTotal, stallViol, syncViol, gapCyc, gapInReady, gapOutValid;

    edge_frame_writer #(.IMG_W(4), .IMG_H(4), .THRESH(0)) dutA (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_mag(magA),
        .in_ready(inReadyA), .out_valid(outValidA), .out_ready(outReady),
        .out_pixel(pixA), .out_sof(sofA), .out_eol(eolA), .frame_done(doneA)
    );

    edge_frame_writer #(.IMG_W(4), .IMG_H(4), .THRESH(100)) dutB (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_mag(magB),
        .in_ready(inReadyB), .out_valid(outValidB), .out_ready(outReady),
        .out_pixel(pixB), .out_sof(sofB), .out_eol(eolB), .frame_done(doneB)
    );

    always #5 clk = ~clk;

    // Drives frames cycle by cycle starting at posedge+1 and records every
    // downstream transfer. readyMode 1 toggles out_ready each cycle; gapLen
    // holds in_valid low for that many cycles before the second interior
    // input of a frame.
    task automatic driveFrames(input int readyMode, input int gapLen,
                               input int maxXfers, input int budget);
        int idx = 0;
        int cyc = 0;
        int gapCnt = 0;
        bit prevStall = 1'b0;
        bit gapNow;
        logic [7:0] prevPix = 8'h00;
        logic prevSof = 1'b0;
        logic prevEol = 1'b0;
        nX = 0; doneTotal = 0; stallViol = 0; syncViol = 0;
        gapCyc = 0; gapInReady = 0; gapOutValid = 0;
        for (int i = 0; i < 64; i++) begin
            capPixA[i] = -1; capPixB[i] = -1; capCyc[i] = -1; capFlags[i] = 3'b000;
        end
        while (nX < maxXfers && cyc < budget) begin
            outReady = (readyMode == 0) ? 1'b1 : (cyc % 2 == 0);
            gapNow   = (gapLen > 0) && (idx % 4 == 1) && (gapCnt < gapLen);
            inValid  = !gapNow;
            magA     = 11'(dataA[idx % 4]);
            magB     = 11'(dataB[idx % 4]);
            #1;
            if (prevStall && (pixA !== prevPix || sofA !== prevSof || eolA !== prevEol))
                stallViol++;
            if (outValidB !== outValidA || inReadyB !== inReadyA || sofB !== sofA ||
                eolB !== eolA || doneB !== doneA)
                syncViol++;
            if (doneA === 1'b1) doneTotal++;
            if (gapNow) begin
                gapCyc++;
                gapCnt++;
                if (inReadyA === 1'b1) gapInReady++;
                if (outValidA === 1'b1) gapOutValid++;
            end
            if (outValidA === 1'b1 && outReady) begin
                capPixA[nX]  = int'(pixA);
                capPixB[nX]  = int'(pixB);
                capCyc[nX]   = cyc;
                capFlags[nX] = {sofA, eolA, doneA};
                nX++;
            end
            prevStall = (outValidA === 1'b1) && !outReady;
            prevPix   = pixA;
            prevSof   = sofA;
            prevEol   = eolA;
            if (inValid && inReadyA === 1'b1) idx++;
            cyc++;
            @(posedge clk); #1;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; inValid = 1'b0; outReady = 1'b1; magA = '0; magB = '0;
        repeat (2) @(posedge clk);
        #1;
        checkCnt++; if (outValidA !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", outValidA); else passCnt++;
        checkCnt++; if (inReadyA !== 1'b0) $display("[TB] FAIL reset_in_ready got %b want 0", inReadyA); else passCnt++;
        checkCnt++; if (doneA !== 1'b0) $display("[TB] FAIL reset_frame_done got %b want 0", doneA); else passCnt++;
        checkCnt++; if (pixA !== 8'h00) $display("[TB] FAIL reset_out_pixel got %0d want 0", pixA); else passCnt++;
        checkCnt++; if (sofA !== 1'b0) $display("[TB] FAIL reset_out_sof got %b want 0", sofA); else passCnt++;
        checkCnt++; if (eolA !== 1'b0) $display("[TB] FAIL reset_out_eol got %b want 0", eolA); else passCnt++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        driveFrames(0, 0, 16, 100);
        checkCnt++; if (nX !== 16) $display("[TB] FAIL basic_xfer_count got %0d want 16", nX); else passCnt++;
        for (int p = 0; p < 16; p++) begin
            checkCnt++;
            if (capPixA[p] !== expA[p]) $display("[TB] FAIL basic_pix_sat[%0d] got %0d want %0d", p, capPixA[p], expA[p]);
            else passCnt++;
            checkCnt++;
            if (capPixB[p] !== expB[p]) $display("[TB] FAIL basic_pix_thresh[%0d] got %0d want %0d", p, capPixB[p], expB[p]);
            else passCnt++;
            checkCnt++;
            if (capFlags[p] !== {p == 0, p % 4 == 3, p == 15})
                $display("[TB] FAIL basic_flags[%0d] got %b want %b", p, capFlags[p], {p == 0, p % 4 == 3, p == 15});
            else passCnt++;
        end
        checkCnt++; if (capCyc[0] !== 2) $display("[TB] FAIL basic_first_latency got %0d want 2", capCyc[0]); else passCnt++;
        checkCnt++; if (capCyc[15] - capCyc[0] !== 15) $display("[TB] FAIL basic_throughput got %0d want 15", capCyc[15] - capCyc[0]); else passCnt++;
        checkCnt++; if (doneTotal !== 1) $display("[TB] FAIL basic_done_pulses got %0d want 1", doneTotal); else passCnt++;
        checkCnt++; if (syncViol !== 0) $display("[TB] FAIL basic_dut_sync got %0d want 0", syncViol); else passCnt++;
    endtask

    task automatic test_stall();
        driveFrames(1, 0, 16, 200);
        checkCnt++; if (nX !== 16) $display("[TB] FAIL stall_xfer_count got %0d want 16", nX); else passCnt++;
        for (int p = 0; p < 16; p++) begin
            checkCnt++;
            if (capPixA[p] !== expA[p]) $display("[TB] FAIL stall_pix[%0d] got %0d want %0d", p, capPixA[p], expA[p]);
            else passCnt++;
        end
        checkCnt++; if (stallViol !== 0) $display("[TB] FAIL stall_stable got %0d want 0", stallViol); else passCnt++;
        checkCnt++; if (doneTotal !== 1) $display("[TB] FAIL stall_done_pulses got %0d want 1", doneTotal); else passCnt++;
    endtask

    task automatic test_input_gap();
        driveFrames(0, 5, 16, 200);
        checkCnt++; if (nX !== 16) $display("[TB] FAIL gap_xfer_count got %0d want 16", nX); else passCnt++;
        for (int p = 0; p < 16; p++) begin
            checkCnt++;
            if (capPixA[p] !== expA[p]) $display("[TB] FAIL gap_pix[%0d] got %0d want %0d", p, capPixA[p], expA[p]);
            else passCnt++;
        end
        checkCnt++; if (gapCyc !== 5) $display("[TB] FAIL gap_cycles got %0d want 5", gapCyc); else passCnt++;
        checkCnt++; if (gapInReady !== 5) $display("[TB] FAIL gap_in_ready got %0d want 5", gapInReady); else passCnt++;
        checkCnt++; if (gapOutValid !== 1) $display("[TB] FAIL gap_out_valid got %0d want 1", gapOutValid); else passCnt++;
    endtask

    task automatic test_mid_reset();
        driveFrames(0, 0, 6, 100);
        checkCnt++; if (nX !== 6) $display("[TB] FAIL midrst_pre_xfers got %0d want 6", nX); else passCnt++;
        #1 rst = 1'b1;
        #1;
        checkCnt++; if (outValidA !== 1'b0) $display("[TB] FAIL midrst_out_valid got %b want 0", outValidA); else passCnt++;
        checkCnt++; if (pixA !== 8'h00) $display("[TB] FAIL midrst_out_pixel got %0d want 0", pixA); else passCnt++;
        checkCnt++; if (inReadyA !== 1'b0) $display("[TB] FAIL midrst_in_ready got %b want 0", inReadyA); else passCnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkCnt++; if (outValidA !== 1'b0) $display("[TB] FAIL midrst_quiet got %b want 0", outValidA); else passCnt++;
        driveFrames(0, 0, 16, 100);
        checkCnt++; if (nX !== 16) $display("[TB] FAIL midrst_xfer_count got %0d want 16", nX); else passCnt++;
        for (int p = 0; p < 16; p++) begin
            checkCnt++;
            if (capPixA[p] !== expA[p]) $display("[TB] FAIL midrst_pix[%0d] got %0d want %0d", p, capPixA[p], expA[p]);
            else passCnt++;
        end
        checkCnt++; if (capFlags[0] !== 3'b100) $display("[TB] FAIL midrst_sof got %b want 100", capFlags[0]); else passCnt++;
        checkCnt++; if (doneTotal !== 1) $display("[TB] FAIL midrst_done_pulses got %0d want 1", doneTotal); else passCnt++;
    endtask

    task automatic test_back_to_back();
        driveFrames(0, 0, 32, 200);
        checkCnt++; if (nX !== 32) $display("[TB] FAIL b2b_xfer_count got %0d want 32", nX); else passCnt++;
        for (int p = 0; p < 32; p++) begin
            checkCnt++;
            if (capPixA[p] !== expA[p % 16]) $display("[TB] FAIL b2b_pix[%0d] got %0d want %0d", p, capPixA[p], expA[p % 16]);
            else passCnt++;
        end
        checkCnt++; if (capFlags[15] !== 3'b011) $display("[TB] FAIL b2b_first_done got %b want 011", capFlags[15]); else passCnt++;
        checkCnt++; if (capFlags[16] !== 3'b100) $display("[TB] FAIL b2b_second_sof got %b want 100", capFlags[16]); else passCnt++;
        checkCnt++; if (capCyc[16] - capCyc[15] !== 3) $display("[TB] FAIL b2b_restart_gap got %0d want 3", capCyc[16] - capCyc[15]); else passCnt++;
        checkCnt++; if (doneTotal !== 2) $display("[TB] FAIL b2b_done_pulses got %0d want 2", doneTotal); else passCnt++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_stall();
        test_input_gap();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
